// File: rtl/ledvideo_axis_source.sv
// ledvideo_axis_source: AXI4-Stream frame generator feeding the ledvideo core.
// Streams COLS x ROWS pixels in raster order with tlast on the final pixel.
// Patterns are solid colour, gradient, checkerboard and pixel index.
// Frames are separated by a programmable idle gap.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no traffic; waiting for enable
// STREAM | presenting pixel (x,y); advances on each handshake
// GAP    | idle between frames; gap down-counter runs to terminal count
module ledvideo_axis_source #(
  parameter int COLS       = 64,
  parameter int ROWS       = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    core_clk,
  input  logic                    core_rst,
  input  logic                    enable,
  input  logic [1:0]              pattern,
  input  logic [23:0]             color,
  input  logic [15:0]             frame_gap,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tlast,
  output logic                    m00_axis_tvalid,
  input  logic                    m00_axis_tready,
  output logic                    busy,
  output logic [15:0]             frame_count
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [1:0]              pat_q, pat_d;
  logic [23:0]             col_q, col_d;
  logic [15:0]             fcnt_q, fcnt_d;
  logic [15:0]             gap_q, gap_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [DATA_WIDTH/8-1:0] tstrb_q, tstrb_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic                    busy_q, busy_d;

  logic                    hs;
  logic                    last_beat;
  logic                    frame_start;
  logic [23:0]             pix;

  // tvalid is high exactly in STREAM, so the handshake needs no state decode
  assign hs        = tvalid_q & m00_axis_tready;
  assign last_beat = (x_q == X_MAX) && (y_q == Y_MAX);

  // State and datapath registers; everything clears asynchronously
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      pat_q    <= '0;
      col_q    <= '0;
      fcnt_q   <= '0;
      gap_q    <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pat_q    <= pat_d;
      col_q    <= col_d;
      fcnt_q   <= fcnt_d;
      gap_q    <= gap_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; frame_start marks the edge where a new frame begins
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          frame_start = 1'b1;
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs && last_beat) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else if (frame_gap == 16'd0) begin
            frame_start = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        // terminal count at 1 gives exactly frame_gap idle cycles
        if (gap_q <= 16'd1) begin
          if (enable) begin
            frame_start = 1'b1;
            state_d     = S_STREAM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, latches and the registered pixel for the beat presented next
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    pat_d  = pat_q;
    col_d  = col_q;
    fcnt_d = fcnt_q;
    gap_d  = gap_q;

    if (state_q == S_STREAM && hs && last_beat) begin
      fcnt_d = fcnt_q + 16'd1;
      gap_d  = frame_gap;
    end else if (state_q == S_GAP) begin
      gap_d = gap_q - 16'd1;
    end

    if (frame_start) begin
      x_d   = '0;
      y_d   = '0;
      pat_d = pattern;
      col_d = color;
    end else if (hs) begin
      // power-of-two sizes wrap naturally back to (0,0) after the last beat
      x_d = x_q + 1'b1;
      if (x_q == X_MAX) begin
        y_d = y_q + 1'b1;
      end
    end

    // pixel is a function of the next coordinates so it lands with the beat;
    // during a stall nothing feeding it changes, keeping tdata stable
    unique case (pat_d)
      2'd0: pix = col_d;
      2'd1: pix = {8'(({x_d, 8'h00}) >> XW), 8'(({y_d, 8'h00}) >> YW), fcnt_d[7:0]};
      2'd2: pix = (x_d[0] ^ y_d[0]) ? 24'hFF_FFFF : 24'h00_0000;
      default: pix = 24'({y_d, x_d});
    endcase

    tvalid_d = (state_d == S_STREAM);
    tdata_d  = tvalid_d ? DATA_WIDTH'(pix) : '0;
    tstrb_d  = tvalid_d ? '1 : '0;
    tlast_d  = tvalid_d && (x_d == X_MAX) && (y_d == Y_MAX);
    busy_d   = (state_d != S_IDLE);
  end

  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = tstrb_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tvalid = tvalid_q;
  assign busy            = busy_q;
  assign frame_count     = fcnt_q;

endmodule

// File: tb/tb_ledvideo_axis_source.sv
// Directed bench for ledvideo_axis_source at COLS=4, ROWS=2.
module tb_ledvideo_axis_source;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd3;
  logic [23:0] color = 24'h0;
  logic [15:0] frame_gap = 16'd0;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        busy;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;

  ledvideo_axis_source #(.COLS(4), .ROWS(2), .DATA_WIDTH(32)) dut (
    .core_clk        (core_clk),
    .core_rst        (core_rst),
    .enable          (enable),
    .pattern         (pattern),
    .color           (color),
    .frame_gap       (frame_gap),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tready (tready),
    .busy            (busy),
    .frame_count     (frame_count)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  logic [23:0] chk_exp [8];
  logic [23:0] grd_exp [8];
  logic [15:0] rdy_vec;
  int          hs;

  initial begin
    chk_exp = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    grd_exp = '{24'h000004, 24'h400004, 24'h800004, 24'hC00004,
                24'h008004, 24'h408004, 24'h808004, 24'hC08004};
    rdy_vec = 16'b1010_0110_0101_1001;

    // reset state
    #12;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_tstrb", 32'(tstrb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fcnt", 32'(frame_count), 32'd0);
    core_rst = 1'b0;
    step();
    check("idle_tvalid", 32'(tvalid), 32'd0);

    // frame 1: index pattern, gap 0, one-cycle start latency
    pattern = 2'd3;
    enable  = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("f1_tvalid", 32'(tvalid), 32'd1);
      check("f1_tdata", tdata, 32'(i));
      check("f1_tlast", 32'(tlast), 32'(i == 7));
      check("f1_tstrb", 32'(tstrb), 32'hF);
      step();
    end
    // frame 2 starts back-to-back; pattern change now only affects frame 3
    check("f2_start_fcnt", 32'(frame_count), 32'd1);
    pattern = 2'd0;
    color   = 24'h12AB34;
    for (int i = 0; i < 8; i++) begin
      check("f2_tdata", tdata, 32'(i));
      check("f2_tlast", 32'(tlast), 32'(i == 7));
      step();
    end

    // frame 3: solid colour with stalls; gap and pattern changed mid-frame
    check("f3_fcnt", 32'(frame_count), 32'd2);
    hs = 0;
    for (int k = 0; k < 40 && hs < 8; k++) begin
      check("f3_tvalid", 32'(tvalid), 32'd1);
      check("f3_tdata", tdata, 32'h0012AB34);
      check("f3_tlast", 32'(tlast), 32'(hs == 7));
      check("f3_tstrb", 32'(tstrb), 32'hF);
      tready = rdy_vec[k % 16];
      if (k == 2) begin
        pattern   = 2'd2;
        frame_gap = 16'd5;
      end
      if (tready) hs++;
      step();
    end
    check("f3_handshakes", 32'(hs), 32'd8);
    tready = 1'b1;

    // gap of 5 idle cycles
    for (int g = 0; g < 5; g++) begin
      check("gap5_tvalid", 32'(tvalid), 32'd0);
      check("gap5_tstrb", 32'(tstrb), 32'd0);
      check("gap5_busy", 32'(busy), 32'd1);
      step();
    end
    check("f4_fcnt", 32'(frame_count), 32'd3);

    // frame 4: checkerboard; set gap 2 and gradient for what follows
    for (int i = 0; i < 8; i++) begin
      check("f4_tvalid", 32'(tvalid), 32'd1);
      check("f4_tdata", tdata, 32'(chk_exp[i]));
      check("f4_tlast", 32'(tlast), 32'(i == 7));
      if (i == 1) begin
        frame_gap = 16'd2;
        pattern   = 2'd1;
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      check("gap2_tvalid", 32'(tvalid), 32'd0);
      step();
    end

    // frame 5: gradient, enable dropped at beat 3
    check("f5_fcnt", 32'(frame_count), 32'd4);
    for (int i = 0; i < 8; i++) begin
      check("f5_tvalid", 32'(tvalid), 32'd1);
      check("f5_tdata", tdata, 32'(grd_exp[i]));
      check("f5_tlast", 32'(tlast), 32'(i == 7));
      if (i == 3) enable = 1'b0;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("stop_tvalid", 32'(tvalid), 32'd0);
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_tlast", 32'(tlast), 32'd0);
      step();
    end
    check("stop_fcnt", 32'(frame_count), 32'd5);

    // reset asserted between edges at beat 5
    pattern = 2'd3;
    enable  = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check("f6_tdata", tdata, 32'(i));
      step();
    end
    check("f6_beat5", tdata, 32'd5);
    #2 core_rst = 1'b1;
    #1;
    check("arst_tvalid", 32'(tvalid), 32'd0);
    check("arst_fcnt", 32'(frame_count), 32'd0);
    check("arst_tdata", tdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(posedge core_clk);
    #2 core_rst = 1'b0;
    step();
    check("post_rst_tvalid", 32'(tvalid), 32'd1);
    check("post_rst_tdata", tdata, 32'd0);
    step();
    check("post_rst_beat1", tdata, 32'd1);
    check("post_rst_fcnt", 32'(frame_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
